// File: rtl/bnn_xnor_classifier.sv
// bnn_xnor_classifier: binarized fully-connected classifier, XNOR-popcount per class, argmax result.
// Ports: clk/rst_n (async active-low); start + img_in launch a classification from IDLE;
// wr_en/wr_neuron/wr_chunk/wr_data load PAR weight bits outside COMPUTE;
// busy during COMPUTE, done one-cycle pulse, result_valid/result_class/result_score hold the winner.
module bnn_xnor_classifier #(
    parameter int N_IN = 784,
    parameter int N_OUT = 10,
    parameter int PAR = 16,
    localparam int N_CHUNK = (N_IN + PAR - 1) / PAR,
    localparam int CLASS_W = N_OUT > 1 ? $clog2(N_OUT) : 1,
    localparam int CHUNK_W = N_CHUNK > 1 ? $clog2(N_CHUNK) : 1,
    localparam int SCORE_W = $clog2(N_IN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_IN-1:0]    img_in,
    input  logic               wr_en,
    input  logic [CLASS_W-1:0] wr_neuron,
    input  logic [CHUNK_W-1:0] wr_chunk,
    input  logic [PAR-1:0]     wr_data,
    output logic               busy,
    output logic               done,
    output logic               result_valid,
    output logic [CLASS_W-1:0] result_class,
    output logic [SCORE_W-1:0] result_score
);
    localparam int IW = N_CHUNK * PAR;
    localparam logic [CHUNK_W-1:0] C_LAST = CHUNK_W'(N_CHUNK - 1);
    localparam logic [CLASS_W-1:0] J_LAST = CLASS_W'(N_OUT - 1);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state;
    logic [PAR-1:0] w [N_OUT][N_CHUNK];
    logic [IW-1:0] img;
    logic [CLASS_W-1:0] j, best_class;
    logic [CHUNK_W-1:0] c;
    logic [SCORE_W-1:0] acc, best_score, pop, sum;
    logic [PAR-1:0] mask, match;
    logic last_chunk, better;

    always_ff @(posedge clk)
        if (wr_en && state != COMPUTE && int'(wr_neuron) < N_OUT && int'(wr_chunk) < N_CHUNK)
            w[wr_neuron][wr_chunk] <= wr_data;

    // padding bits beyond N_IN in the final chunk never count as matches
    for (genvar k = 0; k < PAR; k++) begin : g_mask
        assign mask[k] = int'(c) * PAR + k < N_IN;
    end

    assign match = ~(img[int'(c)*PAR +: PAR] ^ w[j][c]) & mask;

    always_comb begin
        pop = '0;
        for (int k = 0; k < PAR; k++) pop += SCORE_W'(match[k]);
    end

    assign sum = acc + pop;
    assign last_chunk = c == C_LAST;
    // strict compare keeps the lowest index on ties
    assign better = j == '0 || sum > best_score;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            img <= '0;
            j <= '0;
            c <= '0;
            acc <= '0;
            best_class <= '0;
            best_score <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    img <= IW'(img_in);
                    j <= '0;
                    c <= '0;
                    acc <= '0;
                    result_valid <= 1'b0;
                    busy <= 1'b1;
                    state <= COMPUTE;
                end
                COMPUTE: if (!last_chunk) begin
                    acc <= sum;
                    c <= c + CHUNK_W'(1);
                end else begin
                    acc <= '0;
                    c <= '0;
                    j <= j + CLASS_W'(1);
                    if (better) begin
                        best_score <= sum;
                        best_class <= j;
                    end
                    if (j == J_LAST) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        result_valid <= 1'b1;
                        result_class <= better ? j : best_class;
                        result_score <= better ? sum : best_score;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_bnn_xnor_classifier.sv
// tb_bnn_xnor_classifier: randomized and directed checks of the classifier against a pixel-level model.
module tb_bnn_xnor_classifier;
    localparam int SI = 20, SO = 4, SP = 8, SC = 3;
    localparam int DI = 784, DO = 10, DP = 16, DC = 49;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic s_start, s_wr_en, s_busy, s_done, s_rv;
    logic [SI-1:0] s_img;
    logic [1:0] s_wr_neuron, s_wr_chunk, s_class;
    logic [SP-1:0] s_wr_data;
    logic [4:0] s_score;

    logic d_start, d_wr_en, d_busy, d_done, d_rv;
    logic [DI-1:0] d_img;
    logic [3:0] d_wr_neuron, d_class;
    logic [5:0] d_wr_chunk;
    logic [DP-1:0] d_wr_data;
    logic [9:0] d_score;

    logic [SI-1:0] sw_m [SO];
    logic [DI-1:0] dw_m [DO];
    int total = 0, bad = 0;

    bnn_xnor_classifier #(.N_IN(SI), .N_OUT(SO), .PAR(SP)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .img_in(s_img),
        .wr_en(s_wr_en), .wr_neuron(s_wr_neuron), .wr_chunk(s_wr_chunk), .wr_data(s_wr_data),
        .busy(s_busy), .done(s_done), .result_valid(s_rv), .result_class(s_class), .result_score(s_score)
    );

    bnn_xnor_classifier u_dflt (
        .clk(clk), .rst_n(rst_n), .start(d_start), .img_in(d_img),
        .wr_en(d_wr_en), .wr_neuron(d_wr_neuron), .wr_chunk(d_wr_chunk), .wr_data(d_wr_data),
        .busy(d_busy), .done(d_done), .result_valid(d_rv), .result_class(d_class), .result_score(d_score)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int s_match(input int n, input logic [SI-1:0] im);
        int s = 0;
        for (int i = 0; i < SI; i++) s += int'(sw_m[n][i] == im[i]);
        return s;
    endfunction

    function automatic int d_match(input int n, input logic [DI-1:0] im);
        int s = 0;
        for (int i = 0; i < DI; i++) s += int'(dw_m[n][i] == im[i]);
        return s;
    endfunction

    task automatic s_write(input int n, input int ch, input logic [SP-1:0] data);
        @(negedge clk);
        s_wr_en = 1'b1;
        s_wr_neuron = 2'(n);
        s_wr_chunk = 2'(ch);
        s_wr_data = data;
        for (int k = 0; k < SP; k++) if (ch * SP + k < SI) sw_m[n][ch*SP+k] = data[k];
        @(negedge clk);
        s_wr_en = 1'b0;
    endtask

    task automatic s_load(input int n, input logic [SI-1:0] v, input logic [3:0] pad);
        logic [SC*SP-1:0] t;
        t = {pad, v};
        for (int ch = 0; ch < SC; ch++) s_write(n, ch, t[ch*SP +: SP]);
    endtask

    task automatic s_run(input string tag, input logic [SI-1:0] im, input bit disturb, input bit abort);
        int cyc, cls, sc, seen;
        logic [SC*SP-1:0] pt;
        pt = {4'hF, im};
        cls = 0;
        sc = s_match(0, im);
        for (int n = 1; n < SO; n++) if (s_match(n, im) > sc) begin
            sc = s_match(n, im);
            cls = n;
        end
        @(negedge clk);
        s_start = 1'b1;
        s_img = im;
        @(negedge clk);
        s_start = 1'b0;
        s_img = SI'($urandom);
        check({tag, "_busy"}, 32'(s_busy), 1);
        check({tag, "_rv_drop"}, 32'(s_rv), 0);
        cyc = 1;
        while (!s_done && cyc < 40) begin
            if (disturb) begin
                s_start = cyc >= 5 && cyc <= 7;
                s_img = ~im;
                s_wr_en = s_start;
                s_wr_neuron = 2'd0;
                s_wr_chunk = 2'(cyc - 5);
                if (s_start) s_wr_data = pt[(cyc-5)*SP +: SP];
            end
            if (abort && cyc == 6) break;
            @(negedge clk);
            cyc++;
        end
        s_start = 1'b0;
        s_wr_en = 1'b0;
        if (abort) begin
            rst_n = 1'b0;
            #1;
            check({tag, "_busy0"}, 32'(s_busy), 0);
            check({tag, "_done0"}, 32'(s_done), 0);
            check({tag, "_rv0"}, 32'(s_rv), 0);
            check({tag, "_cls0"}, 32'(s_class), 0);
            check({tag, "_score0"}, 32'(s_score), 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (s_done || s_rv) seen = 1;
            end
            check({tag, "_no_done"}, 32'(seen), 0);
        end else begin
            check({tag, "_lat"}, 32'(cyc), SO * SC + 1);
            check({tag, "_cls"}, 32'(s_class), 32'(cls));
            check({tag, "_score"}, 32'(s_score), 32'(sc));
            check({tag, "_rv"}, 32'(s_rv), 1);
            @(negedge clk);
            check({tag, "_pulse"}, 32'(s_done), 0);
            check({tag, "_rv_hold"}, 32'(s_rv), 1);
            check({tag, "_idle"}, 32'(s_busy), 0);
        end
    endtask

    initial begin
        logic [SI-1:0] im;
        logic [DI-1:0] dim;
        int cyc, cls, sc;
        {s_start, s_wr_en, s_img, s_wr_neuron, s_wr_chunk, s_wr_data} = '0;
        {d_start, d_wr_en, d_img, d_wr_neuron, d_wr_chunk, d_wr_data} = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_rv", 32'(s_rv), 0);
        check("rst_cls", 32'(s_class), 0);
        check("rst_score", 32'(s_score), 0);
        check("rst_d_busy", 32'(d_busy), 0);
        check("rst_d_rv", 32'(d_rv), 0);
        check("rst_d_score", 32'(d_score), 0);
        rst_n = 1'b1;

        im = SI'($urandom);
        for (int n = 0; n < SO; n++) s_load(n, n == 2 ? im : ~im, 4'($urandom));
        s_run("match", im, 0, 0);
        check("match_cls_k", 32'(s_class), 2);
        check("match_score_k", 32'(s_score), 20);

        im = SI'($urandom);
        s_load(0, im ^ 20'h000FF, 4'hF);
        s_load(1, im ^ 20'h003FF, 4'hF);
        s_load(2, ~im, 4'hF);
        s_load(3, im ^ 20'hFFF00, 4'hF);
        s_run("pad", im, 0, 0);
        check("pad_cls_k", 32'(s_class), 0);
        check("pad_score_k", 32'(s_score), 12);

        im = SI'($urandom);
        s_load(0, im ^ 20'h07FFF, 4'hF);
        s_load(1, im ^ 20'h0001F, 4'h0);
        s_load(2, im ^ 20'hFFFE0, 4'hF);
        s_load(3, im ^ 20'hF8000, 4'h5);
        s_run("tie", im, 0, 0);
        check("tie_cls_k", 32'(s_class), 1);
        check("tie_score_k", 32'(s_score), 15);

        s_run("proto", im, 1, 0);
        check("proto_cls_k", 32'(s_class), 1);
        check("proto_score_k", 32'(s_score), 15);
        s_load(0, im, 4'hF);
        s_run("rewrite", im, 0, 0);
        check("rewrite_cls_k", 32'(s_class), 0);
        check("rewrite_score_k", 32'(s_score), 20);

        s_run("abort", im, 0, 1);
        s_run("after", im, 0, 0);
        check("after_score_k", 32'(s_score), 20);

        repeat (6) begin
            im = SI'($urandom);
            for (int n = 0; n < SO; n++) s_load(n, SI'($urandom), 4'($urandom));
            s_run("rand", im, 0, 0);
        end

        for (int i = 0; i < DI; i++) dim[i] = 1'($urandom_range(0, 1));
        for (int n = 0; n < DO; n++)
            for (int ch = 0; ch < DC; ch++) begin
                @(negedge clk);
                d_wr_en = 1'b1;
                d_wr_neuron = 4'(n);
                d_wr_chunk = 6'(ch);
                d_wr_data = n == 7 ? dim[ch*DP +: DP] : DP'($urandom);
                dw_m[n][ch*DP +: DP] = d_wr_data;
            end
        @(negedge clk);
        d_wr_en = 1'b0;
        cls = 0;
        sc = d_match(0, dim);
        for (int n = 1; n < DO; n++) if (d_match(n, dim) > sc) begin
            sc = d_match(n, dim);
            cls = n;
        end
        d_start = 1'b1;
        d_img = dim;
        @(negedge clk);
        d_start = 1'b0;
        d_img = '0;
        cyc = 1;
        while (!d_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check("dflt_lat", 32'(cyc), DO * DC + 1);
        check("dflt_cls", 32'(d_class), 32'(cls));
        check("dflt_score", 32'(d_score), 32'(sc));
        check("dflt_cls_k", 32'(d_class), 7);
        check("dflt_score_k", 32'(d_score), 784);
        check("dflt_rv", 32'(d_rv), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
